// File: rtl/datapath_enemy_pkg.sv
// Shared constants, types and helpers for the enemy sprite datapath.
// The optional ENEMY_DESCEND_EN build uses descend_y() to step the sprite down at each edge.
package enemy_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 4;
    localparam int SPRITE_H = 4;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int PCNT_W = 4;
    localparam int DCNT_W = 24;

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - SPRITE_W);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - SPRITE_H);

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // One sprite height down; wrap back to the start row once the sprite would leave the screen.
    function automatic logic [Y_W-1:0] descend_y(input logic [Y_W-1:0] y,
                                                 input logic [Y_W-1:0] y_init);
        logic [Y_W:0] y_next;
        y_next = {1'b0, y} + (Y_W+1)'(SPRITE_H);
        return (y_next > {1'b0, Y_MAX}) ? y_init : y_next[Y_W-1:0];
    endfunction

endpackage

// File: rtl/datapath_enemy_delay_counter.sv
// Free-running movement delay: hold pulses once every DELAY_CYCLES consecutive en_de cycles.
// Dropping en_de restarts the interval from the top.
module delay_counter
    import enemy_pkg::*;
#(
    parameter logic [DCNT_W-1:0] DELAY_CYCLES = 24'd833333
) (
    input  logic clk,
    input  logic reset,
    input  logic en_de,
    output logic hold
);

    localparam logic [DCNT_W-1:0] RELOAD = DELAY_CYCLES - DCNT_W'(1);

    logic [DCNT_W-1:0] dcnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= RELOAD;
        end else if (!en_de || dcnt == '0) begin
            dcnt <= RELOAD;
        end else begin
            dcnt <= dcnt - DCNT_W'(1);
        end
    end

    // Gated by reset so a one-cycle delay cannot pulse while the block is held in reset.
    assign hold = en_de & (dcnt == '0) & ~reset;

endmodule

// File: rtl/datapath_enemy.sv
// Enemy sprite datapath: bounces a 4x4 sprite horizontally and streams its pixels to the VGA adapter.
// Define ENEMY_DESCEND_EN to make the sprite drop one sprite height at every horizontal edge.
module datapath_enemy
    import enemy_pkg::*;
#(
    parameter logic [X_W-1:0]    X_INIT       = 8'd0,
    parameter logic [Y_W-1:0]    Y_INIT       = 7'd0,
    parameter logic [DCNT_W-1:0] DELAY_CYCLES = 24'd833333,
    parameter logic [2:0]        COLOUR       = 3'b100
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           reset_C,
    input  logic           en_XY,
    input  logic           en_de,
    input  logic           erase,
    input  logic           plot,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           plot_out,
    output logic           done,
    output logic           hold
);

    logic [PCNT_W-1:0] pcnt;
    logic [X_W-1:0]    x_pos;
    logic [Y_W-1:0]    y_pos;
    logic [Y_W-1:0]    y_at_edge;
    dir_e              dir;
    logic              at_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (reset_C) begin
            pcnt <= '0;
        end else if (plot) begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // The sprite turns around instead of moving on the step that would take it off screen.
    always_comb begin
        // NOTE: default first so every path assigns at_edge and no latch is inferred.
        at_edge = 1'b0;
        if (dir == DIR_RIGHT) begin
            at_edge = (x_pos >= X_MAX);
        end else begin
            at_edge = (x_pos == '0);
        end
    end

`ifdef ENEMY_DESCEND_EN
    assign y_at_edge = descend_y(y_pos, Y_INIT);
`else
    assign y_at_edge = Y_INIT;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos <= X_INIT;
            y_pos <= Y_INIT;
            dir   <= DIR_RIGHT;
        end else if (en_XY) begin
            if (at_edge) begin
                dir   <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                y_pos <= y_at_edge;
            end else if (dir == DIR_RIGHT) begin
                x_pos <= x_pos + X_W'(1);
            end else begin
                x_pos <= x_pos - X_W'(1);
            end
        end
    end

    assign x_out      = x_pos + X_W'(pcnt[1:0]);
    assign y_out      = y_pos + Y_W'(pcnt[3:2]);
    assign colour_out = erase ? COLOUR_BLACK : COLOUR;
    assign plot_out   = plot;
    assign done       = plot & (pcnt == '1);

    delay_counter #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .en_de(en_de),
        .hold (hold)
    );

endmodule

// File: tb/tb_datapath_enemy.sv
// Scoreboard bench for datapath_enemy: instance A (origin, 5-cycle delay), instance B (x=155, 1-cycle delay).
// Expected descend behaviour follows ENEMY_DESCEND_EN as defined for the build.
module tb_datapath_enemy;

`ifdef ENEMY_DESCEND_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       po;
        logic       done;
        logic       hold;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       reset_C, en_XY, en_de, erase, plot;
    logic       b_reset_C, b_en_XY, b_en_de, b_erase, b_plot;
    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic [2:0] a_col, b_col;
    logic       a_po, a_done, a_hold, b_po, b_done, b_hold;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    datapath_enemy #(
        .X_INIT(8'd0), .Y_INIT(7'd0), .DELAY_CYCLES(24'd5), .COLOUR(3'b100)
    ) dut_a (
        .clk(clk), .reset(reset), .reset_C(reset_C), .en_XY(en_XY), .en_de(en_de),
        .erase(erase), .plot(plot), .x_out(a_x), .y_out(a_y), .colour_out(a_col),
        .plot_out(a_po), .done(a_done), .hold(a_hold)
    );

    datapath_enemy #(
        .X_INIT(8'd155), .Y_INIT(7'd0), .DELAY_CYCLES(24'd1), .COLOUR(3'b100)
    ) dut_b (
        .clk(clk), .reset(reset), .reset_C(b_reset_C), .en_XY(b_en_XY), .en_de(b_en_de),
        .erase(b_erase), .plot(b_plot), .x_out(b_x), .y_out(b_y), .colour_out(b_col),
        .plot_out(b_po), .done(b_done), .hold(b_hold)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d vectors, required completion", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input int x, input int y, input logic [2:0] col,
                                input logic po, input logic dn, input logic hd);
        return {8'(x), 7'(y), col, po, dn, hd};
    endfunction

    function automatic obs_t obs_a();
        return {a_x, a_y, a_col, a_po, a_done, a_hold};
    endfunction

    function automatic obs_t obs_b();
        return {b_x, b_y, b_col, b_po, b_done, b_hold};
    endfunction

    task automatic test_reset();
        obs_t g, e;
        reset = 1'b1;
        #2;
        plot = 1'b1; erase = 1'b1; en_de = 1'b1; b_en_de = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0, 3'b000, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(155, 0, 3'b100, 1'b0, 1'b0, 1'b0));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL reset_a[%0d]: got %h, want %h", k, g, e);
            end
            g = obs_b(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL reset_b[%0d]: got %h, want %h", k, g, e);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b0;
        plot = 1'b0; erase = 1'b0; en_de = 1'b0; b_en_de = 1'b0;
    endtask

    task automatic test_plot_walk();
        obs_t g, e;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            plot = (i < 16);
            if (i < 16) exp_q.push_back(mk(i % 4, i / 4, 3'b100, 1'b1, i == 15, 1'b0));
            else        exp_q.push_back(mk(0, 0, 3'b100, 1'b0, 1'b0, 1'b0));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL plot_walk[%0d]: got x=%0d y=%0d done=%b, want x=%0d y=%0d done=%b",
                         i, g.x, g.y, g.done, e.x, e.y, e.done);
            end
        end
    endtask

    task automatic test_colour();
        obs_t g, e;
        logic ers[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic plt[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic rc[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        int   ex[4]  = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            erase = ers[i]; plot = plt[i]; reset_C = rc[i];
            exp_q.push_back(mk(ex[i], 0, ers[i] ? 3'b000 : 3'b100, plt[i], 1'b0, 1'b0));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL colour[%0d]: got %h, want %h", i, g, e);
            end
        end
        @(negedge clk);
        erase = 1'b0; plot = 1'b0; reset_C = 1'b0;
    endtask

    task automatic test_hold();
        obs_t g, e;
        logic de2[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            en_de = (i < 12) ? 1'b1 : de2[i-12];
            exp_q.push_back(mk(0, 0, 3'b100, 1'b0, 1'b0, (i == 4) || (i == 9) || (i == 19)));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL hold[%0d]: got hold=%b, want hold=%b", i, g.hold, e.hold);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en_de = 1'b0;
            b_en_de = (i < 3);
            exp_q.push_back(mk(155, 0, 3'b100, 1'b0, 1'b0, i < 3));
            #1;
            g = obs_b(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL hold_b[%0d]: got hold=%b, want hold=%b", i, g.hold, e.hold);
            end
        end
        b_en_de = 1'b0;
    endtask

    task automatic test_x_edge();
        obs_t g, e;
        int   dy    = DESC ? 4 : 0;
        logic en[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   ex[6] = '{155, 156, 156, 156, 156, 155};
        int   ey[6];
        ey = '{0, 0, 0, dy, dy, dy};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_en_XY = en[i];
            exp_q.push_back(mk(ex[i], ey[i], 3'b100, 1'b0, 1'b0, 1'b0));
            #1;
            g = obs_b(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL x_edge[%0d]: got x=%0d y=%0d, want x=%0d y=%0d", i, g.x, g.y, e.x, e.y);
            end
        end
        b_en_XY = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t g, e;
        // Fresh start so x_pos, pcnt and dcnt are all known before drawing.
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            plot = 1'b1; en_XY = (i < 7); en_de = 1'b1;
            if (i < 7) exp_q.push_back(mk(i + i % 4, i / 4, 3'b100, 1'b1, 1'b0, i == 4));
            else       exp_q.push_back(mk(7 + 3, 1, 3'b100, 1'b1, 1'b0, 1'b0));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL pre_reset[%0d]: got %h, want %h", i, g, e);
            end
        end
        #1 reset = 1'b1;
        exp_q.push_back(mk(0, 0, 3'b100, 1'b1, 1'b0, 1'b0));
        #1;
        g = obs_a(); e = exp_q.pop_front(); n_vec++;
        if (g !== e) begin
            n_mis++;
            $display("FAIL mid_reset: got %h, want %h", g, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = 1'b0; plot = 1'b0; en_XY = 1'b0; en_de = 1'b1;
            exp_q.push_back(mk(0, 0, 3'b100, 1'b0, 1'b0, i == 4));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL post_reset[%0d]: got %h, want %h", i, g, e);
            end
        end
        @(negedge clk);
        en_de = 1'b0;
    endtask

    // Random plot/en_de/erase/reset_C with en_XY held high long enough to wrap the descend.
    task automatic test_sweep();
        obs_t g, e;
        int   mx = 0, my = 0, mp = 0, md = 4;
        bit   mdir = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int n = 0; n < 4800; n++) begin
            @(negedge clk);
            en_XY   = 1'b1;
            plot    = 1'($urandom_range(0, 1));
            en_de   = 1'($urandom_range(0, 1));
            erase   = 1'($urandom_range(0, 1));
            reset_C = ($urandom_range(0, 15) == 0);
            exp_q.push_back(mk(mx + mp % 4, my + mp / 4, erase ? 3'b000 : 3'b100, plot,
                               plot && (mp == 15), en_de && (md == 0)));
            #1;
            g = obs_a(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL sweep[%0d]: got %h, want %h", n, g, e);
            end
            if (n == 4600) begin
                n_vec++;
                if (a_y !== 7'((DESC ? 116 : 0) + mp / 4)) begin
                    n_mis++;
                    $display("FAIL sweep_bottom: got y=%0d, want y=%0d", a_y, (DESC ? 116 : 0) + mp / 4);
                end
            end
            mp = reset_C ? 0 : (plot ? (mp + 1) % 16 : mp);
            md = (!en_de || md == 0) ? 4 : md - 1;
            if (mdir ? (mx < 156) : (mx > 0)) begin
                mx = mdir ? mx + 1 : mx - 1;
            end else begin
                mdir = !mdir;
                if (DESC) my = (my + 4 > 116) ? 0 : my + 4;
            end
        end
        @(negedge clk);
        en_XY = 1'b0; plot = 1'b0; en_de = 1'b0; erase = 1'b0; reset_C = 1'b1;
        @(negedge clk);
        reset_C = 1'b0;
        exp_q.push_back(mk(90, 0, 3'b100, 1'b0, 1'b0, 1'b0));
        #1;
        g = obs_a(); e = exp_q.pop_front(); n_vec++;
        if (g !== e) begin
            n_mis++;
            $display("FAIL sweep_end: got x=%0d y=%0d, want x=%0d y=%0d", g.x, g.y, e.x, e.y);
        end
    endtask

    initial begin
        reset = 1'b1;
        reset_C = 1'b0; en_XY = 1'b0; en_de = 1'b0; erase = 1'b0; plot = 1'b0;
        b_reset_C = 1'b0; b_en_XY = 1'b0; b_en_de = 1'b0; b_erase = 1'b0; b_plot = 1'b0;
        test_reset();
        test_plot_walk();
        test_colour();
        test_hold();
        test_x_edge();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/datapath_enemy.md
DATAPATH_ENEMY -- requirements
Module: datapath_enemy

Interface
REQ-001 Parameter X_INIT, default 8'd0, reset x position of sprite top-left corner.
REQ-002 Parameter Y_INIT, default 7'd0, reset y position and descend wrap target.
REQ-003 Parameter DELAY_CYCLES, default 24'd833333, en_de cycles per hold pulse; legal range 1..2^24-1.
REQ-004 Parameter COLOUR, default 3'b100, sprite colour while drawing.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 reset_C  in  1  clear pixel counter.
REQ-008 en_XY  in  1  advance sprite position one step.
REQ-009 en_de  in  1  enable delay counter.
REQ-010 erase  in  1  select black colour.
REQ-011 plot  in  1  pixel write request, advances pixel counter.
REQ-012 x_out  out  8  VGA pixel x.
REQ-013 y_out  out  7  VGA pixel y.
REQ-014 colour_out  out  3  VGA pixel colour.
REQ-015 plot_out  out  1  VGA write enable.
REQ-016 done  out  1  last sprite pixel being plotted.
REQ-017 hold  out  1  delay interval complete.

Function
REQ-018 Sprite is 4x4 pixels; 4-bit pixel counter pcnt; x_out = x_pos + pcnt[1:0], y_out = y_pos + pcnt[3:2], combinational from registers.
REQ-019 pcnt: reset_C=1 -> 0 (priority); else plot=1 -> pcnt+1, wrapping 15->0; else hold value.
REQ-020 done = plot & (pcnt==15), combinational; same edge that samples done wraps pcnt to 0.
REQ-021 plot_out = plot; colour_out = erase ? 3'b000 : COLOUR.
REQ-022 Delay counter dcnt 24 bits: en_de=0 -> load DELAY_CYCLES-1; en_de=1 and dcnt==0 -> reload DELAY_CYCLES-1; en_de=1 otherwise -> dcnt-1.
REQ-023 hold = en_de & (dcnt==0); first hold on DELAY_CYCLES-th consecutive en_de cycle; DELAY_CYCLES=1 gives hold every en_de cycle.
REQ-024 Direction register dir (1=right). On en_XY: dir=1 and x_pos<156, or dir=0 and x_pos>0 -> x_pos moves 1 in dir; otherwise x_pos unchanged, dir inverts, edge event raised.
REQ-025 en_XY=0 -> x_pos, y_pos, dir hold.
REQ-026 en_XY, plot, en_de independent; simultaneous assertion performs every enabled update on the same edge.
REQ-027 x_pos never exceeds 156, y_pos never exceeds 116, so x_out<=159 and y_out<=119.

Reset
REQ-028 reset=1 asynchronously: pcnt=0, dcnt=DELAY_CYCLES-1, x_pos=X_INIT, y_pos=Y_INIT, dir=1.
REQ-029 During reset: x_out=X_INIT, y_out=Y_INIT, done=0, hold=0; plot_out and colour_out follow inputs.
REQ-030 Reset mid-draw abandons the sprite; no completion pulse is owed afterwards.

Configuration
REQ-031 Macro ENEMY_DESCEND_EN defined: edge event sets y_pos = y_pos+4, or Y_INIT when y_pos+4 > 116.
REQ-032 ENEMY_DESCEND_EN undefined: y_pos constant at Y_INIT; dir still inverts at edges.

Structure
REQ-033 Package enemy_pkg holds SCREEN_W=160, SCREEN_H=120, SPRITE_W=4, SPRITE_H=4, X_MAX=156, Y_MAX=116, COLOUR_BLACK=3'b000, coordinate width constants.
REQ-034 Sub-module delay_counter (parameter DELAY_CYCLES; ports clk, reset, en_de, hold) implements REQ-022/023.

Verification
REQ-035 Reset, then plot=1 for 16 cycles -> (x_out,y_out) walks (0,0),(1,0),(2,0),(3,0),(0,1)..(3,3); done=1 only on 16th cycle; pcnt=0 after.
REQ-036 DELAY_CYCLES=5, en_de held high 12 cycles -> hold high on cycles 5 and 10 only; en_de dropped on cycle 3 then re-raised -> next hold 5 cycles later.
REQ-037 X_INIT=155, en_XY pulsed 3 times -> x_pos 156, 156 (dir->0), 155.
REQ-038 ENEMY_DESCEND_EN defined, Y_INIT=0, x_pos=156, dir=1, en_XY -> y_pos=4; from y_pos=116 edge -> y_pos=0. Undefined -> y_pos stays 0.
REQ-039 erase=1, plot=1 -> colour_out=000, plot_out=1; erase=0 -> colour_out=COLOUR.
REQ-040 reset asserted between clock edges at pcnt=7 -> pcnt, x_pos, dcnt restored immediately, before next edge.
